// File: rtl/axi_wmaster_pkg.sv
// axi_wmaster_pkg: shared burst/response constants, the write-master FSM state
// type and the per-beat address/strobe arithmetic used by axi_wstrb_gen.
// The helper functions work on the widest supported address and strobe
// vectors; callers slice the results down to their own widths.
package axi_wmaster_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_STRB_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_t;

  // Address of the beat that follows a beat at 'addr'. WRAP assumes the
  // start address was aligned and len is a legal wrap length.
  function automatic logic [MAX_ADDR_W-1:0] next_beat_addr(
    input logic [MAX_ADDR_W-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst,
    input logic [7:0]            len
  );
    logic [MAX_ADDR_W-1:0] beat_bytes;
    logic [MAX_ADDR_W-1:0] aligned;
    logic [MAX_ADDR_W-1:0] incr;
    logic [MAX_ADDR_W-1:0] wrap_mask;
    beat_bytes = MAX_ADDR_W'(1) << size;
    aligned    = addr & ~(beat_bytes - MAX_ADDR_W'(1));
    incr       = aligned + beat_bytes;
    wrap_mask  = (beat_bytes * (MAX_ADDR_W'(len) + MAX_ADDR_W'(1))) - MAX_ADDR_W'(1);
    case (burst)
      BURST_INCR: next_beat_addr = incr;
      BURST_WRAP: next_beat_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:    next_beat_addr = addr;
    endcase
  endfunction

  // Byte lanes written by a beat at 'addr': from the addressed lane up to
  // (not including) the next 2^size-aligned lane.
  function automatic logic [MAX_STRB_W-1:0] beat_strb(
    input logic [MAX_ADDR_W-1:0] addr,
    input logic [2:0]            size,
    input int                    strb_w
  );
    logic [7:0]            lane_lo;
    logic [7:0]            lane_hi;
    logic [7:0]            bytes;
    logic [MAX_STRB_W-1:0] lo_mask;
    logic [MAX_STRB_W-1:0] hi_mask;
    bytes   = 8'd1 << size;
    lane_lo = {1'b0, addr[6:0]} & 8'(strb_w - 1);
    lane_hi = (lane_lo & ~(bytes - 8'd1)) + bytes;
    lo_mask = (MAX_STRB_W'(1) << lane_lo) - MAX_STRB_W'(1);
    hi_mask = (MAX_STRB_W'(1) << lane_hi) - MAX_STRB_W'(1);
    beat_strb = hi_mask & ~lo_mask;
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// axi_wstrb_gen: combinational beat helper. Given the current beat address
// and the burst shape it produces that beat's write strobe and the address
// of the following beat.
module axi_wstrb_gen
  import axi_wmaster_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STRB_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  input  logic [7:0]        len,
  output logic [STRB_W-1:0] strb,
  output logic [ADDR_W-1:0] next_addr
);

  logic [MAX_ADDR_W-1:0] addr_ext;
  logic [MAX_ADDR_W-1:0] next_ext;
  logic [MAX_STRB_W-1:0] strb_ext;

  // Widen the address, run the shared arithmetic, narrow the results back
  always_comb begin
    addr_ext = MAX_ADDR_W'(addr);
    next_ext = next_beat_addr(addr_ext, size, burst, len);
    strb_ext = beat_strb(addr_ext, size, STRB_W);
  end

  assign next_addr = next_ext[ADDR_W-1:0];
  assign strb      = strb_ext[STRB_W-1:0];

  generate
    if (ADDR_W < MAX_ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^next_ext[MAX_ADDR_W-1:ADDR_W];
    end
    if (STRB_W < MAX_STRB_W) begin : g_strb_hi
      logic unused_strb_hi;
      assign unused_strb_hi = ^strb_ext[MAX_STRB_W-1:STRB_W];
    end
  endgenerate

endmodule

// File: rtl/axi_burst_write_master.sv
// axi_burst_write_master: single-outstanding AXI4 write initiator. Takes one
// command plus a write-data stream, issues AW, the W beats with lane strobes
// derived from the beat address, collects B and reports completion.
// Optional build macro AXI_WMASTER_4KB_CHECK_EN: when defined, INCR commands
// whose last byte crosses a 4KB boundary are rejected locally as SLVERR.
module axi_burst_write_master
  import axi_wmaster_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8
) (
  input  logic                        axi_clk,
  input  logic                        axi_resetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic [2:0]                  cmd_size,
  input  logic [1:0]                  cmd_burst,
  input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
  input  logic                        wd_valid,
  output logic                        wd_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   wd_data,
  output logic                        done_valid,
  input  logic                        done_ready,
  output logic [1:0]                  done_resp,
  output logic [AXI_ID_WIDTH-1:0]     done_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  output logic [1:0]                  axi_aw_burst,
  output logic [2:0]                  axi_aw_size,
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
  output logic [7:0]                  axi_aw_len,
  output logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  output logic                        axi_w_last,
  output logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  input  logic [1:0]                  axi_b_resp,
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
  input  logic                        axi_b_valid,
  output logic                        axi_b_ready
);

  localparam int         AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] STRB_LOG2      = 3'($clog2(AXI_STRB_WIDTH));

  state_t                      state_q;
  state_t                      state_d;
  logic [AXI_ADDR_WIDTH-1:0]   beat_addr_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;
  logic [7:0]                  len_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [8:0]                  beat_cnt_q;
  logic                        beats_left;
  logic                        w_load;
  logic                        local_err;
  logic [6:0]                  size_mask;
  logic [AXI_STRB_WIDTH-1:0]   beat_strb_c;
  logic [AXI_ADDR_WIDTH-1:0]   next_addr_c;
`ifdef AXI_WMASTER_4KB_CHECK_EN
  logic [19:0]                 last_byte;
`endif

  axi_wstrb_gen #(
    .ADDR_W (AXI_ADDR_WIDTH),
    .STRB_W (AXI_STRB_WIDTH)
  ) u_strb_gen (
    .addr      (beat_addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .len       (len_q),
    .strb      (beat_strb_c),
    .next_addr (next_addr_c)
  );

  assign beats_left = (beat_cnt_q <= {1'b0, len_q});

  // Commands that can never be issued legally are answered locally
  always_comb begin
    local_err = 1'b0;
    size_mask = 7'((8'd1 << cmd_size) - 8'd1);
    if (cmd_size > STRB_LOG2) local_err = 1'b1;
    if (cmd_burst == 2'd3) local_err = 1'b1;
    if (cmd_burst == BURST_WRAP) begin
      if (!(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) local_err = 1'b1;
      if ((cmd_addr[6:0] & size_mask) != 7'd0) local_err = 1'b1;
    end
`ifdef AXI_WMASTER_4KB_CHECK_EN
    last_byte = ({8'd0, cmd_addr[11:0]} & ~{13'd0, size_mask})
              + ((20'(cmd_len) + 20'd1) << cmd_size) - 20'd1;
    if ((cmd_burst == BURST_INCR) && (last_byte[19:12] != 8'd0)) local_err = 1'b1;
`endif
  end

  // FSM state register
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic and the handshake signals that follow directly from state
  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    axi_aw_valid = 1'b0;
    w_load       = 1'b0;
    wd_ready     = 1'b0;
    axi_b_ready  = 1'b0;
    done_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = local_err ? ST_DONE : ST_ADDR;
      end
      ST_ADDR: begin
        axi_aw_valid = 1'b1;
        if (axi_aw_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        w_load   = wd_valid && (!axi_w_valid || axi_w_ready) && beats_left;
        wd_ready = w_load;
        if (axi_w_valid && axi_w_ready && axi_w_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, W output register and completion payload
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      beat_addr_q  <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      len_q        <= '0;
      id_q         <= '0;
      beat_cnt_q   <= '0;
      axi_aw_addr  <= '0;
      axi_aw_burst <= '0;
      axi_aw_size  <= '0;
      axi_aw_id    <= '0;
      axi_aw_len   <= '0;
      axi_w_data   <= '0;
      axi_w_strb   <= '0;
      axi_w_last   <= 1'b0;
      axi_w_valid  <= 1'b0;
      done_resp    <= RESP_OKAY;
      done_id      <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        beat_addr_q  <= cmd_addr;
        size_q       <= cmd_size;
        burst_q      <= cmd_burst;
        len_q        <= cmd_len;
        id_q         <= cmd_id;
        beat_cnt_q   <= '0;
        axi_aw_addr  <= cmd_addr;
        axi_aw_burst <= cmd_burst;
        axi_aw_size  <= cmd_size;
        axi_aw_id    <= cmd_id;
        axi_aw_len   <= cmd_len;
        if (local_err) begin
          done_resp <= RESP_SLVERR;
          done_id   <= cmd_id;
        end
      end
      if (w_load) begin
        axi_w_data  <= wd_data;
        axi_w_strb  <= beat_strb_c;
        axi_w_last  <= (beat_cnt_q == {1'b0, len_q});
        axi_w_valid <= 1'b1;
        beat_cnt_q  <= beat_cnt_q + 9'd1;
        beat_addr_q <= next_addr_c;
      end else if (axi_w_valid && axi_w_ready) begin
        axi_w_valid <= 1'b0;
      end
      if (axi_b_valid && axi_b_ready) begin
        done_resp <= (axi_b_id != id_q) ? RESP_SLVERR : axi_b_resp;
        done_id   <= id_q;
      end
    end
  end

endmodule

// File: doc/axi_burst_write_master.md
Name: axi_burst_write_master

Overview:
- Synthesizable AXI4 write initiator: the master end of the AW/W/B channels that axi_simple_dual_port_ram serves as slave.
- Accepts one command (addr/len/size/burst/id) plus a data stream.
- Issues AW, then W beats with per-beat byte strobes derived from address and size, then collects B and reports completion.
- One outstanding transaction; intended for DMA-style fills of the RAM and for byte-access verification of it.

Parameters:
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width (8..1024, power of 2)
- AXI_ID_WIDTH, 8, transaction ID width
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width (derived, not overridden)

Ports:
- axi_clk  in  1  clock
- axi_resetn  in  1  reset; asynchronous, active-low
- cmd_valid/cmd_ready  in/out  1/1  command handshake
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address
- cmd_len  in  8  beats-1
- cmd_size  in  3  log2 bytes per beat
- cmd_burst  in  2  FIXED=0, INCR=1, WRAP=2
- cmd_id  in  AXI_ID_WIDTH  transaction ID
- wd_valid/wd_ready  in/out  1/1  write-data stream handshake
- wd_data  in  AXI_DATA_WIDTH  beat data, lane-positioned by the producer
- done_valid/done_ready  out/in  1/1  completion handshake
- done_resp  out  2  final response
- done_id  out  AXI_ID_WIDTH  ID of the completed command
- axi_aw_addr/burst/size/id/len/valid  out  per AXI4  write address channel
- axi_aw_ready  in  1  write address ready
- axi_w_data/strb/last/valid  out  per AXI4  write data channel
- axi_w_ready  in  1  write data ready
- axi_b_resp/id/valid  in  2/ID/1  write response channel
- axi_b_ready  out  1  write response ready

Behaviour:
- Reset values:
  - All valids and readys (except cmd_ready) and all payload outputs are 0.
  - cmd_ready=1.
  - FSM=IDLE.
  - Reset is asynchronous; outputs clear immediately, even mid-burst, with no recovery of bus state.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
  - IDLE: cmd_ready=1. On cmd handshake, latch the command; next state is ADDR, or DONE with a local error (see checks).
  - ADDR: axi_aw_valid=1 from the cycle after acceptance, payload held stable until axi_aw_ready; then DATA.
  - DATA: W starts only after the AW handshake.
    - The W output register is loaded when wd_valid && (!axi_w_valid || axi_w_ready) and beats remain.
    - wd_ready is that same condition, gated by state==DATA.
    - Payload is stable while axi_w_valid && !axi_w_ready.
    - axi_w_last=1 on beat cmd_len+1. After the last handshake, next state is RESP.
  - RESP: axi_b_ready=1. On B handshake, latch resp; next state is DONE.
    - If axi_b_id != latched id, done_resp=2'b10 (SLVERR).
  - DONE: done_valid=1, held with done_resp/done_id until done_ready; then IDLE.
- Address sequence per beat (beat address A):
  - FIXED: A is constant.
  - INCR: first A = cmd_addr; subsequent A = aligned(A, size) + 2^size.
  - WRAP: boundary = 2^size*(len+1); A wraps to the boundary-aligned base.
- Strobe per beat:
  - Lanes from A mod STRB_WIDTH up to the next 2^size-aligned byte, exclusive.
  - So an unaligned first beat has its low lanes cleared; aligned beats set 2^size contiguous lanes.
- Local errors: no AW/W issued, done_resp=2'b10 within 2 cycles.
  - cmd_size > log2(AXI_STRB_WIDTH).
  - WRAP with len not in {1,3,7,15}.
  - WRAP with unaligned cmd_addr.
  - cmd_burst==3.
- Simultaneous events:
  - W load and accept in the same cycle are allowed (full throughput, 1 beat/cycle).
  - B arriving early is not possible; b_ready is low outside RESP.
- Latency: cmd accept to axi_aw_valid is 1 cycle.

Optional Feature:
- Macro AXI_WMASTER_4KB_CHECK_EN.
  - Defined: an INCR command whose last byte crosses a 4KB boundary is rejected as a local SLVERR with no bus activity.
  - Undefined: the command is issued unchanged.

Decomposition:
- Package axi_wmaster_pkg holds:
  - burst and resp constants (BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR)
  - the state enum
  - the functions next_beat_addr() and beat_strb()
- Sub-module axi_wstrb_gen: combinational; given addr, size, burst, len, produces current strobe and next address. Instantiated once.

Test Plan:
1. INCR addr 0x100, len 3, size 2 (32-bit bus) -> 4 W beats, strb 0xF each, last on beat 4, done_resp 0, done_id = cmd_id.
2. INCR addr 0x101, size 2, len 1 -> strb 0xE then 0xF.
3. INCR addr 0x002, size 0, len 3 -> strb 0x4, 0x8, 0x1, 0x2.
4. WRAP addr 0x108, size 2, len 3 -> beat addrs 0x108, 0x10C, 0x100, 0x104, strb 0xF.
5. WRAP with len 2 -> no axi_aw_valid, done_resp 2'b10.
6. Random low axi_w_ready/axi_aw_ready and slave b_resp 2'b10 -> payloads stable under stall, done_resp 2'b10; then assert axi_resetn low mid-DATA -> all valids 0 immediately, and the next command completes OKAY.
